if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the 5-stage pipelined RV32I CPU in `Top`. It sits between the instruction memory `im` and the decode stage. It holds the PC and drives the `im` read address. It applies static backward-taken/forward-not-taken (BTFN) prediction to B-type branches and JAL. It registers the IF/ID pipeline bundle, obeying stall and redirect (flush) requests from the hazard unit and the EX stage.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `PREDICT_EN`, default `1`: 0 disables prediction, so next PC is always PC+4 unless redirected.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `stall_i  in  1`: hazard unit holds the PC and IF/ID.
- `redirect_i  in  1`: EX resolved a mispredict or JALR; flush and refetch.
- `redirect_pc_i  in  32`: target for `redirect_i`; bits [1:0] are cleared internally.
- `im_addr_o  out  32`: instruction-memory byte address, equal to the current PC.
- `im_rdata_i  in  32`: instruction word, combinationally valid in the same cycle as `im_addr_o`.
- `id_valid_o  out  1`: IF/ID holds a real instruction.
- `id_pc_o  out  32`: PC of the IF/ID instruction.
- `id_instr_o  out  32`: instruction word; `32'h0000_0013` (NOP) when invalid.
- `id_pred_taken_o  out  1`: IF predicted taken.
- `id_pred_target_o  out  32`: predicted target; PC+4 when not taken.

## Operation
- State is `pc_q` plus the IF/ID register set plus a 1-bit FSM.
- **FSM states:**
  - `BOOT`: entered on reset. Lasts one cycle. Fetch is suppressed, so IF/ID receives a bubble.
  - `RUN`: entered after `BOOT`. Stays in `RUN` until reset.
- **Prediction, combinational on `im_rdata_i`:**
  - opcode `1101111` (JAL): taken; target = PC + J-imm.
  - opcode `1100011` (branch) with imm[12]=1 (backward): taken; target = PC + B-imm.
  - Any other case: not taken; target = PC+4.
- **Next-PC priority:**
  1. `redirect_i` → `redirect_pc_i & ~3`.
  2. `stall_i` → hold `pc_q`.
  3. `BOOT` → hold `pc_q`.
  4. Predicted taken → target.
  5. Otherwise → PC+4.
- **IF/ID update:**
  - `redirect_i`: load bubble (valid=0, instr=NOP, pred_taken=0). Redirect wins over a simultaneous `stall_i`.
  - `stall_i` without redirect: hold all IF/ID fields.
  - `BOOT`: load bubble.
  - Otherwise: load valid=1, pc=`pc_q`, instr=`im_rdata_i`, plus the prediction result.
- **Arithmetic:** all PC adds are 32-bit and wrap modulo 2^32 (`32'hFFFF_FFFC`+4 = 0). Immediates are sign-extended to 32 bits.
- **Reset mid-operation:** outputs reach their reset values immediately on assertion, with no dependence on the clock.

## Timing
- **Reset values:**
  - `pc_q`=`RESET_PC`, FSM=`BOOT`.
  - `id_valid_o`=0, `id_pc_o`=0, `id_instr_o`=`32'h13`, `id_pred_taken_o`=0, `id_pred_target_o`=0.
  - `im_addr_o` = `RESET_PC`.
- **Fetch latency:** first valid IF/ID appears two rising edges after `rst` deasserts (the `BOOT` edge plus the fetch edge).
- **Throughput:** one instruction per cycle without stall or redirect.
- **Predicted-taken:** the target is fetched on the next cycle, with no bubble.
- **Redirect penalty:** the IF/ID bubble appears on the edge that samples `redirect_i`. The redirected instruction is valid in IF/ID on the following edge.
- **Stall:** no change to `im_addr_o` or IF/ID outputs while `stall_i`=1. Stall may last any number of cycles.

## Structure
- **`cpu_pkg` (shared):**
  - `OPC_BRANCH`, `OPC_JAL`, `OPC_JALR`.
  - `NOP_INSTR = 32'h0000_0013`.
  - Functions `imm_b(instr)` and `imm_j(instr)` returning sign-extended 32-bit values.
  - Typedef `if_id_t` packing valid/pc/instr/pred_taken/pred_target, so decode uses the same struct.
- **Sub-module `btfn_predictor`:** purely combinational. Inputs are pc and instr; outputs are taken and target.
- **`if_stage` itself:** owns the PC register, FSM and IF/ID register.

## Test plan
1. **Reset:** hold `rst` 3 cycles, `RESET_PC`=0. IF/ID stays invalid/NOP during reset and the `BOOT` cycle. Then valid instructions appear with pc=0, 4, 8 on successive edges.
2. **Backward branch:** branch at pc `0x40`, imm=-16. `id_pred_taken_o`=1, `id_pred_target_o`=`0x30`. The next valid pc is `0x30`.
3. **Forward branch and JAL:** forward branch at `0x20`, imm=+8 → not taken, next pc `0x24`. JAL at `0x24`, imm=+0x100 → next pc `0x124`, with no bubble.
4. **Stall:** assert `stall_i` 3 cycles while IF/ID holds pc `0x10`. Outputs are frozen; `im_addr_o` stays `0x14`. After release, IF/ID pc becomes `0x14`.
5. **Redirect with stall:** `redirect_i`=1, `stall_i`=1, `redirect_pc_i`=`0x203`. Next edge gives a bubble and `im_addr_o`=`0x200`. The following edge gives valid pc `0x200`.
6. **Wrap and async reset:**
   - PC at `0xFFFF_FFFC` with a non-branch instruction wraps to 0.
   - Asserting `rst` mid-cycle clears outputs before the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, NOP encoding, immediate helpers
// and the IF/ID pipeline bundle used by fetch and decode.
package cpu_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } if_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        logic [31:0] pred_target;
    } if_id_t;

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7],
                instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12],
                instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/btfn_predictor.sv
// Static predictor: JAL and backward branches taken,
// everything else falls through to pc+4.
module btfn_predictor
    import cpu_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        taken_o,
    output logic [31:0] target_o
);

    logic [6:0] opc;

    assign opc = instr_i[6:0];

    // Pick direction and target from the opcode and immediate sign
    always_comb begin
        taken_o  = 1'b0;
        target_o = pc_i + 32'd4;
        if (opc == OPC_JAL) begin
            taken_o  = 1'b1;
            target_o = pc_i + imm_j(instr_i);
        end else if (opc == OPC_BRANCH && instr_i[31]) begin
            taken_o  = 1'b1;
            target_o = pc_i + imm_b(instr_i);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, one-cycle boot FSM and
// IF/ID register with stall/redirect handling.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          PREDICT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] im_addr_o,
    input  logic [31:0] im_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o,
    output logic        id_pred_taken_o,
    output logic [31:0] id_pred_target_o
);

    if_state_e   state_q, state_d;
    logic        fetch_en;
    logic [31:0] pc_q, pc_d;
    if_id_t      id_q, id_d;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic        taken;
    logic [31:0] target;

    btfn_predictor u_bp (
        .pc_i     (pc_q),
        .instr_i  (im_rdata_i),
        .taken_o  (bp_taken),
        .target_o (bp_target)
    );

    assign taken  = PREDICT_EN && bp_taken;
    assign target = taken ? bp_target : pc_q + 32'd4;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    // FSM next state: BOOT lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // FSM output: fetch is only enabled once out of BOOT
    always_comb begin
        fetch_en = (state_q == RUN);
    end

    // Next PC by priority: redirect, stall, boot, prediction
    always_comb begin
        pc_d = pc_q;
        if (redirect_i)    pc_d = redirect_pc_i & ~32'd3;
        else if (stall_i)  pc_d = pc_q;
        else if (!fetch_en) pc_d = pc_q;
        else               pc_d = target;
    end

    // Next IF/ID bundle; redirect bubbles even under stall
    always_comb begin
        id_d = id_q;
        if (redirect_i || (!stall_i && !fetch_en)) begin
            id_d.valid       = 1'b0;
            id_d.pc          = 32'd0;
            id_d.instr       = NOP_INSTR;
            id_d.pred_taken  = 1'b0;
            id_d.pred_target = 32'd0;
        end else if (!stall_i) begin
            id_d.valid       = 1'b1;
            id_d.pc          = pc_q;
            id_d.instr       = im_rdata_i;
            id_d.pred_taken  = taken;
            id_d.pred_target = target;
        end
    end

    // PC and IF/ID registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            id_q.valid       <= 1'b0;
            id_q.pc          <= 32'd0;
            id_q.instr       <= NOP_INSTR;
            id_q.pred_taken  <= 1'b0;
            id_q.pred_target <= 32'd0;
        end else begin
            pc_q <= pc_d;
            id_q <= id_d;
        end
    end

    assign im_addr_o        = pc_q;
    assign id_valid_o       = id_q.valid;
    assign id_pc_o          = id_q.pc;
    assign id_instr_o       = id_q.instr;
    assign id_pred_taken_o  = id_q.pred_taken;
    assign id_pred_target_o = id_q.pred_target;

endmodule
